bsg_dmc_ui_arbiter: RTL

//  Shares one bsg_dmc user interface (app_* cmd / write-data / read-data channels) among num_req_p requesters.

---
 rtl/bsg_dmc_pearl_pkg.sv | 14 +
 rtl/bsg_dmc_pkg.sv | 9 +
 rtl/bsg_fifo_1r1w_small.sv | 51 +++++
 rtl/bsg_dmc_ui_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_dmc_pearl_pkg.sv
// State encodings for the control blocks around bsg_dmc.
package bsg_dmc_pearl_pkg;

  // state    | meaning
  // eIdle    | pick the next requester round-robin
  // eCmd     | owner's command presented to the DMC
  // eWrData  | owner's write burst forwarded to the DMC
  typedef enum logic [1:0] {
    eIdle   = 2'd0,
    eCmd    = 2'd1,
    eWrData = 2'd2
  } bsg_dmc_ui_arb_state_e;

endpackage

// File: rtl/bsg_dmc_pkg.sv
// Command encoding shared by every block that talks to the bsg_dmc user interface.
package bsg_dmc_pkg;

  typedef enum logic [2:0] {
    WR = 3'b000,
    RD = 3'b001
  } app_cmd_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small flop-based FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 1,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                push, pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign full_o = (count_r == cnt_w_lp'(els_p));
  assign v_o    = (count_r != '0);
  assign data_o = mem_r[rptr_r];
  assign pop    = yumi_i & v_o;
  assign push   = v_i & (~full_o | pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= ptr_inc(wptr_r);
      if (pop)  rptr_r <= ptr_inc(rptr_r);
      if (push & ~pop)      count_r <= count_r + cnt_w_lp'(1);
      else if (pop & ~push) count_r <= count_r - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_dmc_ui_arbiter.sv
// Shares one bsg_dmc user interface among num_req_p requesters: round-robin command
// arbitration, grant held through the write burst, read data routed by an in-order tag FIFO.
module bsg_dmc_ui_arbiter
  import bsg_dmc_pkg::*;
  import bsg_dmc_pearl_pkg::*;
#(
  parameter int num_req_p       = 2,
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 32,
  parameter int ui_burst_len_p  = 4,
  parameter int tag_fifo_els_p  = 8
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,

  input  logic [num_req_p*ui_addr_width_p-1:0]        req_app_addr_i,
  input  logic [num_req_p*$bits(app_cmd_e)-1:0]       req_app_cmd_i,
  input  logic [num_req_p-1:0]                        req_app_en_i,
  output logic [num_req_p-1:0]                        req_app_rdy_o,
  input  logic [num_req_p-1:0]                        req_app_wdf_wren_i,
  input  logic [num_req_p*ui_data_width_p-1:0]        req_app_wdf_data_i,
  input  logic [num_req_p*(ui_data_width_p>>3)-1:0]   req_app_wdf_mask_i,
  input  logic [num_req_p-1:0]                        req_app_wdf_end_i,
  output logic [num_req_p-1:0]                        req_app_wdf_rdy_o,
  output logic [num_req_p-1:0]                        req_app_rd_data_valid_o,
  output logic [ui_data_width_p-1:0]                  req_app_rd_data_o,
  output logic [num_req_p-1:0]                        req_app_rd_data_end_o,

  output logic [ui_addr_width_p-1:0]                  app_addr_o,
  output app_cmd_e                                    app_cmd_o,
  output logic                                        app_en_o,
  input  logic                                        app_rdy_i,
  output logic                                        app_wdf_wren_o,
  output logic [ui_data_width_p-1:0]                  app_wdf_data_o,
  output logic [(ui_data_width_p>>3)-1:0]             app_wdf_mask_o,
  output logic                                        app_wdf_end_o,
  input  logic                                        app_wdf_rdy_i,
  input  logic                                        app_rd_data_valid_i,
  input  logic [ui_data_width_p-1:0]                  app_rd_data_i,
  input  logic                                        app_rd_data_end_i,

  output logic [$clog2(num_req_p)-1:0]                grant_id_o
);

  localparam int lg_req_lp = $clog2(num_req_p);
  localparam int mask_w_lp = ui_data_width_p >> 3;
  localparam int cmd_w_lp  = $bits(app_cmd_e);
  localparam int cnt_w_lp  = (ui_burst_len_p > 1) ? $clog2(ui_burst_len_p) : 1;

  bsg_dmc_ui_arb_state_e state_r, state_n;
  logic [lg_req_lp-1:0]  grant_id_r, grant_id_n;
  logic [lg_req_lp-1:0]  rr_r, rr_n;
  logic [cnt_w_lp-1:0]   beat_cnt_r, beat_cnt_n;

  logic [ui_addr_width_p-1:0] own_addr;
  app_cmd_e                   own_cmd;
  logic                       own_en, own_wren, own_end, own_is_rd;
  logic [ui_data_width_p-1:0] own_data;
  logic [mask_w_lp-1:0]       own_mask;

  logic                 tag_full, tag_v, tag_push, tag_pop;
  logic [lg_req_lp-1:0] tag_head;
  logic                 rd_blocked, cmd_ok, cmd_fire, wdf_fire, last_beat;

  logic [num_req_p-1:0] eligible;
  logic                 rr_found;
  logic [lg_req_lp-1:0] rr_winner;
  int                   idx;

  assign own_addr  = req_app_addr_i[grant_id_r*ui_addr_width_p +: ui_addr_width_p];
  assign own_cmd   = app_cmd_e'(req_app_cmd_i[grant_id_r*cmd_w_lp +: cmd_w_lp]);
  assign own_en    = req_app_en_i[grant_id_r];
  assign own_wren  = req_app_wdf_wren_i[grant_id_r];
  assign own_data  = req_app_wdf_data_i[grant_id_r*ui_data_width_p +: ui_data_width_p];
  assign own_mask  = req_app_wdf_mask_i[grant_id_r*mask_w_lp +: mask_w_lp];
  assign own_end   = req_app_wdf_end_i[grant_id_r];
  assign own_is_rd = (own_cmd == RD);

  // A read return that ends this cycle frees a tag slot in time for a new read.
  assign tag_pop    = app_rd_data_valid_i & app_rd_data_end_i & tag_v;
  assign rd_blocked = tag_full & ~tag_pop;
  assign cmd_ok     = ~(own_is_rd & rd_blocked);
  assign cmd_fire   = (state_r == eCmd) & own_en & cmd_ok & app_rdy_i;
  assign wdf_fire   = (state_r == eWrData) & own_wren & app_wdf_rdy_i;
  assign last_beat  = (beat_cnt_r == cnt_w_lp'(ui_burst_len_p - 1));
  assign tag_push   = cmd_fire & own_is_rd;

  bsg_fifo_1r1w_small #(
    .width_p(lg_req_lp),
    .els_p  (tag_fifo_els_p)
  ) tag_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (tag_push),
    .data_i (grant_id_r),
    .yumi_i (tag_pop),
    .full_o (tag_full),
    .v_o    (tag_v),
    .data_o (tag_head)
  );

  // rr_r holds the first index to search (last owner + 1), so its reset value 0 favours req 0.
  always_comb begin
    eligible  = '0;
    rr_found  = 1'b0;
    rr_winner = '0;
    idx       = 0;
    for (int i = 0; i < num_req_p; i++) begin
      eligible[i] = req_app_en_i[i]
                  & ~(rd_blocked & (req_app_cmd_i[i*cmd_w_lp +: cmd_w_lp] == RD));
    end
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_r) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!rr_found && eligible[idx]) begin
        rr_found  = 1'b1;
        rr_winner = lg_req_lp'(idx);
      end
    end
  end

  always_comb begin
    state_n           = state_r;
    grant_id_n        = grant_id_r;
    rr_n              = rr_r;
    beat_cnt_n        = beat_cnt_r;
    app_en_o          = 1'b0;
    req_app_rdy_o     = '0;
    app_wdf_wren_o    = 1'b0;
    req_app_wdf_rdy_o = '0;
    case (state_r)
      eIdle: begin
        if (rr_found) begin
          grant_id_n = rr_winner;
          state_n    = eCmd;
        end
      end
      eCmd: begin
        app_en_o                  = own_en & cmd_ok;
        req_app_rdy_o[grant_id_r] = app_rdy_i & cmd_ok;
        if (cmd_fire) begin
          rr_n    = (grant_id_r == lg_req_lp'(num_req_p - 1)) ? '0 : grant_id_r + lg_req_lp'(1);
          state_n = own_is_rd ? eIdle : eWrData;
        end
      end
      eWrData: begin
        app_wdf_wren_o                = own_wren;
        req_app_wdf_rdy_o[grant_id_r] = app_wdf_rdy_i;
        if (wdf_fire) begin
          if (last_beat) begin
            beat_cnt_n = '0;
            state_n    = eIdle;
          end else begin
            beat_cnt_n = beat_cnt_r + cnt_w_lp'(1);
          end
        end
      end
      default: state_n = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= eIdle;
      grant_id_r <= '0;
      rr_r       <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_n;
      grant_id_r <= grant_id_n;
      rr_r       <= rr_n;
      beat_cnt_r <= beat_cnt_n;
    end
  end

  always_comb begin
    req_app_rd_data_valid_o = '0;
    req_app_rd_data_end_o   = '0;
    if (app_rd_data_valid_i & tag_v) begin
      req_app_rd_data_valid_o[tag_head] = 1'b1;
      req_app_rd_data_end_o[tag_head]   = app_rd_data_end_i;
    end
  end

  assign req_app_rd_data_o = app_rd_data_i;
  assign app_addr_o        = own_addr;
  assign app_cmd_o         = own_cmd;
  assign app_wdf_data_o    = own_data;
  assign app_wdf_mask_o    = own_mask;
  assign app_wdf_end_o     = (state_r == eWrData) & last_beat;
  assign grant_id_o        = grant_id_r;

  wdf_end_matches_count: assert property (@(posedge clk_i) disable iff (reset_i)
    wdf_fire |-> (own_end == last_beat));

  rd_data_has_tag: assert property (@(posedge clk_i) disable iff (reset_i)
    app_rd_data_valid_i |-> tag_v);

endmodule
